// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction-fetch stage.
//   ifu_state_e    - fetch FSM state encoding
//   IFU_FAULT_INST - instruction word presented on a misaligned-PC fault
//   IFU_RESET_PC   - default architectural reset PC
package ifu_pkg;

   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {
      S_REQ      = 2'd0,
      S_WAIT_RSP = 2'd1,
      S_HOLD     = 2'd2,
      S_WAIT_PC  = 2'd3
   } ifu_state_e;

   localparam logic [XLEN-1:0] IFU_FAULT_INST = 32'h0000_0000;
   localparam logic [XLEN-1:0] IFU_RESET_PC   = 32'h8000_0000;

endpackage

// File: rtl/ifu_fetch.sv
// ifu_fetch: multicycle instruction-fetch stage owning the architectural PC.
// One instruction in flight: request -> response -> hand to decode -> take dnpc.
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   pc_update_valid/ready, dnpc    - next PC from the next-PC stage
//   imem_req_valid/ready/addr      - instruction-memory read request
//   imem_rsp_valid/ready/data/err  - instruction-memory read response
//   inst_valid/ready, inst,
//   inst_pc, inst_fault            - fetched instruction to decode
//   fetch_count                    - instructions handed to decode (wraps)
module ifu_fetch
   import ifu_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = IFU_RESET_PC,
   parameter int unsigned     CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pc_update_valid,
   output logic             pc_update_ready,
   input  logic [XLEN-1:0]  dnpc,
   output logic             imem_req_valid,
   input  logic             imem_req_ready,
   output logic [XLEN-1:0]  imem_req_addr,
   input  logic             imem_rsp_valid,
   output logic             imem_rsp_ready,
   input  logic [XLEN-1:0]  imem_rsp_data,
   input  logic             imem_rsp_err,
   output logic             inst_valid,
   input  logic             inst_ready,
   output logic [XLEN-1:0]  inst,
   output logic [XLEN-1:0]  inst_pc,
   output logic             inst_fault,
   output logic [CNT_W-1:0] fetch_count
);

   ifu_state_e       state_q, state_d;
   logic [XLEN-1:0]  pc_q, pc_d;
   logic [XLEN-1:0]  inst_q, inst_d;
   logic [XLEN-1:0]  inst_pc_q, inst_pc_d;
   logic             inst_fault_q, inst_fault_d;
   logic [CNT_W-1:0] fetch_count_q, fetch_count_d;
   logic             pc_misaligned;

   assign pc_misaligned = (pc_q[1:0] != 2'b00);

   // State register and datapath flops
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_REQ;
         pc_q          <= RESET_PC;
         inst_q        <= '0;
         inst_pc_q     <= '0;
         inst_fault_q  <= 1'b0;
         fetch_count_q <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         inst_q        <= inst_d;
         inst_pc_q     <= inst_pc_d;
         inst_fault_q  <= inst_fault_d;
         fetch_count_q <= fetch_count_d;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      inst_d        = inst_q;
      inst_pc_d     = inst_pc_q;
      inst_fault_d  = inst_fault_q;
      fetch_count_d = fetch_count_q;

      case (state_q)
         S_REQ: begin
            // Misaligned PC faults locally without touching the bus
            if (pc_misaligned) begin
               inst_d       = IFU_FAULT_INST;
               inst_pc_d    = pc_q;
               inst_fault_d = 1'b1;
               state_d      = S_HOLD;
            end else if (imem_req_ready) begin
               state_d = S_WAIT_RSP;
            end
         end
         S_WAIT_RSP: begin
            if (imem_rsp_valid) begin
               inst_d       = imem_rsp_data;
               inst_pc_d    = pc_q;
               inst_fault_d = imem_rsp_err;
               state_d      = S_HOLD;
            end
         end
         S_HOLD: begin
            if (inst_ready) begin
               fetch_count_d = fetch_count_q + CNT_W'(1);
               state_d       = S_WAIT_PC;
            end
         end
         S_WAIT_PC: begin
            if (pc_update_valid) begin
               pc_d    = dnpc;
               state_d = S_REQ;
            end
         end
         default: state_d = S_REQ;
      endcase
   end

   // Handshake outputs decode directly from the registered state
   assign imem_req_valid  = (state_q == S_REQ) && !pc_misaligned;
   assign imem_req_addr   = pc_q;
   assign imem_rsp_ready  = (state_q == S_WAIT_RSP);
   assign inst_valid      = (state_q == S_HOLD);
   assign pc_update_ready = (state_q == S_WAIT_PC);
   assign inst            = inst_q;
   assign inst_pc         = inst_pc_q;
   assign inst_fault      = inst_fault_q;
   assign fetch_count     = fetch_count_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: self-checking bench for ifu_fetch with a scoreboard queue of
// expected instructions pushed at request time and popped at decode handshake.
module tb_ifu_fetch;
   import ifu_pkg::*;

   localparam logic [31:0] RST_PC = 32'h8000_0000;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic        fault;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        pc_update_valid;
   logic        pc_update_ready;
   logic [31:0] dnpc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic        imem_rsp_ready;
   logic [31:0] imem_rsp_data;
   logic        imem_rsp_err;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_fault;
   logic [31:0] fetch_count;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] model_pc;
   logic [31:0] model_cnt;
   exp_t        sb[$];

   ifu_fetch #(.RESET_PC(RST_PC), .CNT_W(32)) dut (
      .clk(clk), .rst(rst),
      .pc_update_valid(pc_update_valid), .pc_update_ready(pc_update_ready), .dnpc(dnpc),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_ready(imem_rsp_ready),
      .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
      .inst_pc(inst_pc), .inst_fault(inst_fault), .fetch_count(fetch_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Outputs are sampled and inputs changed 1ns after each rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full fetch starting in S_REQ and ending back in S_REQ at next_pc
   task automatic do_fetch(input int req_stall, input int rsp_delay,
                           input logic [31:0] data, input logic err,
                           input int hold_stall, input logic [31:0] next_pc,
                           input logic pcv_early, input string tag);
      exp_t e;
      e = '0;
      if (model_pc[1:0] == 2'b00) begin
         for (int i = 0; i < req_stall; i++) begin
            imem_req_ready = 1'b0;
            checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== model_pc || imem_rsp_ready !== 1'b0) begin
               errors++;
               $display("FAIL %s req_stall%0d: valid=%b addr=%h rsp_rdy=%b expected valid=1 addr=%h rsp_rdy=0",
                        tag, i, imem_req_valid, imem_req_addr, imem_rsp_ready, model_pc);
            end
            tick();
         end
         checks++;
         if (imem_req_valid !== 1'b1 || imem_req_addr !== model_pc || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s req_issue: valid=%b addr=%h inst_valid=%b expected valid=1 addr=%h inst_valid=0",
                     tag, imem_req_valid, imem_req_addr, inst_valid, model_pc);
         end
         e.inst = data; e.pc = model_pc; e.fault = err;
         sb.push_back(e);
         imem_req_ready = 1'b1;
         tick();
         imem_req_ready = 1'b0;
         for (int i = 0; i <= rsp_delay; i++) begin
            checks++;
            if (imem_rsp_ready !== 1'b1 || inst_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
               errors++;
               $display("FAIL %s wait_rsp%0d: rsp_rdy=%b inst_valid=%b req_valid=%b expected 1 0 0",
                        tag, i, imem_rsp_ready, inst_valid, imem_req_valid);
            end
            if (i == rsp_delay) begin
               imem_rsp_valid = 1'b1;
               imem_rsp_data  = data;
               imem_rsp_err   = err;
            end
            tick();
         end
         imem_rsp_valid = 1'b0;
         imem_rsp_err   = 1'b0;
         imem_rsp_data  = 32'h0;
      end else begin
         checks++;
         if (imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s misalign_no_req: req_valid=%b expected 0", tag, imem_req_valid);
         end
         e.inst = IFU_FAULT_INST; e.pc = model_pc; e.fault = 1'b1;
         sb.push_back(e);
         tick();
      end

      // S_HOLD: instruction presented, held stable while decode stalls
      checks++;
      if (inst_valid !== 1'b1 || pc_update_ready !== 1'b0) begin
         errors++;
         $display("FAIL %s hold_entry: inst_valid=%b pc_upd_rdy=%b expected 1 0", tag, inst_valid, pc_update_ready);
      end
      if (sb.size() != 0) e = sb[0];
      pc_update_valid = pcv_early;
      dnpc            = next_pc;
      for (int i = 0; i < hold_stall; i++) begin
         // Stray response on the bus must be ignored outside S_WAIT_RSP
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = 32'hBAD0_0000 | 32'(i);
         checks++;
         if (inst_valid !== 1'b1 || pc_update_ready !== 1'b0 || imem_rsp_ready !== 1'b0 ||
             inst !== e.inst || inst_pc !== e.pc || inst_fault !== e.fault) begin
            errors++;
            $display("FAIL %s hold_stall%0d: v=%b pur=%b rr=%b inst=%h pc=%h f=%b expected 1 0 0 %h %h %b",
                     tag, i, inst_valid, pc_update_ready, imem_rsp_ready, inst, inst_pc, inst_fault,
                     e.inst, e.pc, e.fault);
         end
         tick();
      end
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;

      inst_ready = 1'b1;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL %s sb_empty: inst=%h pc=%h with no expected entry", tag, inst, inst_pc);
      end else begin
         e = sb.pop_front();
         if (inst !== e.inst || inst_pc !== e.pc || inst_fault !== e.fault) begin
            errors++;
            $display("FAIL %s inst_out: inst=%h pc=%h fault=%b expected %h %h %b",
                     tag, inst, inst_pc, inst_fault, e.inst, e.pc, e.fault);
         end
      end
      tick();
      inst_ready = 1'b0;
      model_cnt  = model_cnt + 32'd1;

      // S_WAIT_PC: instruction still readable, dnpc accepted now
      checks++;
      if (inst_valid !== 1'b0 || pc_update_ready !== 1'b1 || fetch_count !== model_cnt || inst !== e.inst) begin
         errors++;
         $display("FAIL %s wait_pc: inst_valid=%b pc_upd_rdy=%b count=%0d inst=%h expected 0 1 %0d %h",
                  tag, inst_valid, pc_update_ready, fetch_count, inst, model_cnt, e.inst);
      end
      pc_update_valid = 1'b1;
      dnpc            = next_pc;
      tick();
      pc_update_valid = 1'b0;
      model_pc        = next_pc;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      model_pc  = RST_PC;
      model_cnt = 32'd0;
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC || imem_rsp_ready !== 1'b0 ||
          inst_valid !== 1'b0 || pc_update_ready !== 1'b0 || inst !== 32'h0 ||
          inst_pc !== 32'h0 || inst_fault !== 1'b0 || fetch_count !== 32'd0) begin
         errors++;
         $display("FAIL reset: rv=%b ra=%h rr=%b iv=%b pur=%b i=%h ipc=%h f=%b cnt=%0d expected 1 %h 0 0 0 0 0 0 0",
                  imem_req_valid, imem_req_addr, imem_rsp_ready, inst_valid, pc_update_ready,
                  inst, inst_pc, inst_fault, fetch_count, RST_PC);
      end
   endtask

   task automatic test_basic();
      do_fetch(0, 0, 32'h0000_0093, 1'b0, 0, 32'h8000_0008, 1'b0, "basic");
   endtask

   task automatic test_req_stall();
      do_fetch(3, 2, 32'h0010_0113, 1'b0, 0, 32'h8000_000C, 1'b0, "req_stall");
   endtask

   task automatic test_hold_stall();
      do_fetch(0, 0, 32'h0020_0193, 1'b0, 4, 32'h8000_0004, 1'b1, "hold_stall");
   endtask

   task automatic test_bus_err();
      do_fetch(0, 0, 32'hDEAD_BEEF, 1'b1, 1, 32'h8000_0002, 1'b0, "bus_err");
   endtask

   task automatic test_misaligned();
      do_fetch(0, 0, 32'h0, 1'b0, 2, 32'h8000_0010, 1'b1, "misaligned");
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 6; k++) begin
         do_fetch(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), $urandom,
                  1'(k == 4), int'($urandom_range(0, 2)), model_pc + 32'd4, 1'(k[0]), "b2b");
      end
   endtask

   task automatic test_reset_mid();
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== model_pc) begin
         errors++;
         $display("FAIL rst_mid_req: valid=%b addr=%h expected 1 %h", imem_req_valid, imem_req_addr, model_pc);
      end
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sb.delete();
      model_pc  = RST_PC;
      model_cnt = 32'd0;
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC || fetch_count !== 32'd0 ||
          inst_valid !== 1'b0 || imem_rsp_ready !== 1'b0 || inst !== 32'h0) begin
         errors++;
         $display("FAIL rst_mid: rv=%b ra=%h cnt=%0d iv=%b rr=%b inst=%h expected 1 %h 0 0 0 0",
                  imem_req_valid, imem_req_addr, fetch_count, inst_valid, imem_rsp_ready, inst, RST_PC);
      end
      do_fetch(0, 0, 32'h0000_0013, 1'b0, 0, 32'h8000_0004, 1'b0, "post_rst");
   endtask

   initial begin
      rst             = 1'b1;
      pc_update_valid = 1'b0;
      dnpc            = 32'h0;
      imem_req_ready  = 1'b0;
      imem_rsp_valid  = 1'b0;
      imem_rsp_data   = 32'h0;
      imem_rsp_err    = 1'b0;
      inst_ready      = 1'b0;
      model_pc        = RST_PC;
      model_cnt       = 32'd0;

      test_reset();
      test_basic();
      test_req_stall();
      test_hold_stall();
      test_bus_err();
      test_misaligned();
      test_back_to_back();
      test_reset_mid();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
Multicycle instruction-fetch stage. It sits directly downstream of the next-PC logic and owns the architectural PC register. It accepts the next PC (dnpc) over a valid/ready handshake, issues one instruction-memory read, and presents the fetched instruction with its PC to the decode stage. Exactly one instruction is in flight at a time.

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset; also the first fetch address.
CNT_W, 32, width of the retired-fetch performance counter.

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
pc_update_valid  input  1  dnpc is valid for the current instruction
pc_update_ready  output  1  block accepts dnpc this cycle
dnpc  input  32  next PC from the next-PC stage
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts the request
imem_req_addr  output  32  fetch address; equals pc
imem_rsp_valid  input  1  read data valid
imem_rsp_ready  output  1  block accepts the response
imem_rsp_data  input  32  instruction word
imem_rsp_err  input  1  bus error on this response
inst_valid  output  1  instruction available to decode
inst_ready  input  1  decode consumes the instruction
inst  output  32  instruction word
inst_pc  output  32  PC of inst
inst_fault  output  1  fetch fault: misaligned PC or bus error
fetch_count  output  CNT_W  count of instructions handed to decode

Behaviour:
- States: S_REQ, S_WAIT_RSP, S_HOLD, S_WAIT_PC (2-bit encoding).
- Reset values:
  - state=S_REQ, pc=RESET_PC.
  - inst=0, inst_pc=0, inst_fault=0, fetch_count=0.
  - All valid/ready outputs are 0 in the first cycle after reset, except imem_req_valid, which follows the S_REQ rules below.
- S_REQ:
  - If pc[1:0]!=0: no bus request is issued (imem_req_valid=0). Set inst=32'h0000_0000, inst_pc=pc, inst_fault=1, go to S_HOLD next cycle.
  - Otherwise imem_req_valid=1, imem_req_addr=pc. Valid and address stay stable until imem_req_ready. On the handshake, go to S_WAIT_RSP.
- S_WAIT_RSP:
  - imem_rsp_ready=1.
  - On imem_rsp_valid: inst<=imem_rsp_data, inst_pc<=pc, inst_fault<=imem_rsp_err, go to S_HOLD.
  - A response is never accepted outside this state.
- S_HOLD:
  - inst_valid=1. inst, inst_pc and inst_fault are held stable until inst_ready.
  - On inst_ready: fetch_count increments (wraps modulo 2^CNT_W), go to S_WAIT_PC.
- S_WAIT_PC:
  - pc_update_ready=1.
  - On pc_update_valid: pc<=dnpc, go to S_REQ.
  - inst stays readable but inst_valid=0.
- pc_update_ready is 0 in every state except S_WAIT_PC. pc_update_valid in S_HOLD (even the same cycle as inst_ready) is not consumed; the upstream stage must hold it.
- Minimum latency, with memory ready and a response on the cycle after the request: REQ→WAIT_RSP→HOLD, so inst_valid rises 2 cycles after entering S_REQ.
- Bus-error and misaligned faults still pass through S_HOLD and S_WAIT_PC. Trap redirection is the next-PC stage's job.
- Reset mid-operation returns to S_REQ at RESET_PC immediately, abandoning any outstanding request. The instruction memory shares rst, so no stale response may arrive afterwards.
- pc is never incremented internally; the only sources of pc are RESET_PC and dnpc.

Decomposition:
- Package ifu_pkg holds:
  - typedef enum logic [1:0] ifu_state_e {S_REQ, S_WAIT_RSP, S_HOLD, S_WAIT_PC}
  - localparam IFU_FAULT_INST = 32'h0
  - localparam IFU_RESET_PC (default for RESET_PC)
- Single module; no sub-module is warranted. The counter is an inline always block.

Test Plan:
- Release rst with memory always ready and a 1-cycle response of 32'h0000_0093 → imem_req_addr=0x8000_0000 in the first cycle. Two cycles later inst_valid=1, inst=0x0000_0093, inst_pc=0x8000_0000, inst_fault=0.
- Hold imem_req_ready low for 3 cycles → imem_req_valid and addr stay stable for those 3 cycles. The response arrives only after acceptance, and inst_valid waits for it.
- Hold inst_ready low for 4 cycles in S_HOLD, with pc_update_valid=1 and dnpc=0x8000_0004 → pc_update_ready=0 throughout. After inst_ready: fetch_count=1, the next cycle accepts dnpc, and the next request goes to 0x8000_0004.
- dnpc=0x8000_0002 → no imem_req_valid pulse. inst_valid=1 with inst_fault=1, inst=0, inst_pc=0x8000_0002.
- Response with imem_rsp_err=1 and data 0xDEAD_BEEF → inst_fault=1, inst=0xDEAD_BEEF, inst_pc matches the request address.
- Assert rst while in S_WAIT_RSP → the next cycle is state S_REQ with imem_req_addr=0x8000_0000, fetch_count=0, inst_valid=0.
